// File: rtl/token_tx.sv
// token_tx: tagged token FIFO feeding separate sign/number handshake ports.
// Optional input HOLD (blocks popping while idle) is added when TOKEN_TX_HOLD_EN is defined.
module token_tx #(
    parameter int DEPTH = 8
) (
    input  logic                     CLK,
    input  logic                     RST,
`ifdef TOKEN_TX_HOLD_EN
    input  logic                     HOLD,
`endif
    input  logic                     WR_STB,
    input  logic                     WR_TAG,
    input  logic [7:0]               WR_DAT,
    output logic                     WR_ACK,
    output logic [7:0]               SIGN_DAT,
    output logic                     SIGN_STB,
    input  logic                     SIGN_ACK,
    output logic [7:0]               NUMBER_DAT,
    output logic                     NUMBER_STB,
    input  logic                     NUMBER_ACK,
    output logic                     BUSY,
    output logic                     FULL,
    output logic [$clog2(DEPTH):0]   COUNT
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic {IDLE, SEND} state_t;

    state_t          state;
    logic [8:0]      mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [CW-1:0]   count_nxt;
    logic [8:0]      head;
    logic            push;
    logic            pop;
    logic            hold;

`ifdef TOKEN_TX_HOLD_EN
    assign hold = HOLD;
`else
    assign hold = 1'b0;
`endif

    assign WR_ACK = WR_STB & ~FULL & ~RST;
    assign push   = WR_ACK;
    assign pop    = (state == IDLE) && (COUNT != '0) && !hold;
    assign head   = mem[rd_ptr];
    assign BUSY   = (state == SEND) | (COUNT != '0);

    // occupancy after this edge's push/pop
    always_comb begin
        count_nxt = COUNT + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    end

    // token storage, written at the tail on each accepted write
    always_ff @(posedge CLK) begin
        if (push) mem[wr_ptr] <= {WR_TAG, WR_DAT};
    end

    // pointers wrap naturally at DEPTH; FULL tracks the next occupancy so it stays registered
    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            COUNT  <= '0;
            FULL   <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            COUNT <= count_nxt;
            FULL  <= (count_nxt == CW'(DEPTH));
        end
    end

    // send FSM: pop into the class register, hold STB until the matching ACK
    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= IDLE;
            SIGN_STB   <= 1'b0;
            NUMBER_STB <= 1'b0;
            SIGN_DAT   <= '0;
            NUMBER_DAT <= '0;
        end else if (state == IDLE) begin
            if (pop) begin
                state <= SEND;
                if (head[8]) begin
                    SIGN_DAT <= head[7:0];
                    SIGN_STB <= 1'b1;
                end else begin
                    NUMBER_DAT <= head[7:0];
                    NUMBER_STB <= 1'b1;
                end
            end
        end else if ((SIGN_STB && SIGN_ACK) || (NUMBER_STB && NUMBER_ACK)) begin
            state      <= IDLE;
            SIGN_STB   <= 1'b0;
            NUMBER_STB <= 1'b0;
        end
    end
endmodule

// File: tb/tb_token_tx.sv
// tb_token_tx: scenario tasks plus a randomized scoreboard run against token_tx.
module tb_token_tx;
    localparam int DEPTH = 8;
    localparam int CW = $clog2(DEPTH) + 1;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          HOLD = 1'b0;
    logic          WR_STB = 1'b0;
    logic          WR_TAG = 1'b0;
    logic [7:0]    WR_DAT = 8'h00;
    logic          WR_ACK;
    logic [7:0]    SIGN_DAT;
    logic          SIGN_STB;
    logic          SIGN_ACK = 1'b0;
    logic [7:0]    NUMBER_DAT;
    logic          NUMBER_STB;
    logic          NUMBER_ACK = 1'b0;
    logic          BUSY;
    logic          FULL;
    logic [CW-1:0] COUNT;

    int checks = 0;
    int failures = 0;
    logic [8:0] obs[$];
    logic [7:0] exp_num = 8'h00;
    logic [7:0] exp_sign = 8'h00;

    token_tx #(.DEPTH(DEPTH)) dut (
        .CLK(CLK),
        .RST(RST),
`ifdef TOKEN_TX_HOLD_EN
        .HOLD(HOLD),
`endif
        .WR_STB(WR_STB),
        .WR_TAG(WR_TAG),
        .WR_DAT(WR_DAT),
        .WR_ACK(WR_ACK),
        .SIGN_DAT(SIGN_DAT),
        .SIGN_STB(SIGN_STB),
        .SIGN_ACK(SIGN_ACK),
        .NUMBER_DAT(NUMBER_DAT),
        .NUMBER_STB(NUMBER_STB),
        .NUMBER_ACK(NUMBER_ACK),
        .BUSY(BUSY),
        .FULL(FULL),
        .COUNT(COUNT)
    );

    always #5 CLK = ~CLK;

    // record every completed handshake as {tag, data}
    always @(posedge CLK) begin
        if (!RST) begin
            if (SIGN_STB && SIGN_ACK) obs.push_back({1'b1, SIGN_DAT});
            if (NUMBER_STB && NUMBER_ACK) obs.push_back({1'b0, NUMBER_DAT});
        end
    end

    task automatic note_sent(input logic [8:0] t);
        if (t[8]) exp_sign = t[7:0];
        else exp_num = t[7:0];
    endtask

    task automatic test_reset;
        @(negedge CLK);
        RST = 1'b1; WR_STB = 1'b1; WR_TAG = 1'b0; WR_DAT = 8'hAA;
        #1;
        checks++;
        if (WR_ACK !== 1'b0) begin failures++; $display("FAIL reset_wr_ack got=%b want=0", WR_ACK); end
        @(negedge CLK);
        checks++;
        if ({SIGN_STB, NUMBER_STB, BUSY, FULL} !== 4'b0000) begin
            failures++; $display("FAIL reset_flags got=%b want=0000", {SIGN_STB, NUMBER_STB, BUSY, FULL});
        end
        checks++;
        if (COUNT !== '0) begin failures++; $display("FAIL reset_count got=%0d want=0", COUNT); end
        checks++;
        if ({SIGN_DAT, NUMBER_DAT} !== 16'h0000) begin
            failures++; $display("FAIL reset_dat got=%h want=0000", {SIGN_DAT, NUMBER_DAT});
        end
        RST = 1'b0; WR_STB = 1'b0;
        @(negedge CLK);
        checks++;
        if ({BUSY, COUNT} !== '0) begin failures++; $display("FAIL reset_no_store got=%b,%0d want=0,0", BUSY, COUNT); end
        exp_num = 8'h00; exp_sign = 8'h00;
        obs.delete();
    endtask

    task automatic test_single;
        logic [5:0] num_tr;
        logic sign_seen;
        logic [7:0] dat1;
        logic busy_end;
        num_tr = '0; sign_seen = 1'b0; dat1 = 8'h00; busy_end = 1'b1;
        SIGN_ACK = 1'b1; NUMBER_ACK = 1'b1;
        WR_STB = 1'b1; WR_TAG = 1'b0; WR_DAT = 8'h05;
        #1;
        checks++;
        if (WR_ACK !== 1'b1) begin failures++; $display("FAIL single_wr_ack got=%b want=1", WR_ACK); end
        for (int n = 0; n < 6; n++) begin
            @(negedge CLK);
            WR_STB = 1'b0;
            num_tr[n] = NUMBER_STB;
            sign_seen |= SIGN_STB;
            if (n == 1) dat1 = NUMBER_DAT;
            if (n == 5) busy_end = BUSY;
        end
        note_sent(9'h005);
        checks++;
        if (num_tr !== 6'b000010) begin failures++; $display("FAIL single_stb_trace got=%b want=000010", num_tr); end
        checks++;
        if (sign_seen !== 1'b0) begin failures++; $display("FAIL single_sign_stb got=%b want=0", sign_seen); end
        checks++;
        if (dat1 !== 8'h05) begin failures++; $display("FAIL single_dat got=%h want=05", dat1); end
        checks++;
        if (busy_end !== 1'b0) begin failures++; $display("FAIL single_busy got=%b want=0", busy_end); end
        checks++;
        if (obs.size() != 1 || obs[0] !== 9'h005) begin
            failures++; $display("FAIL single_obs got_n=%0d want_n=1", obs.size());
        end
        obs.delete();
    endtask

    task automatic test_sequence;
        logic [8:0] toks[3];
        logic [9:0] stb_tr;
        logic both;
        toks[0] = 9'h003; toks[1] = 9'h12B; toks[2] = 9'h004;
        stb_tr = '0; both = 1'b0;
        SIGN_ACK = 1'b1; NUMBER_ACK = 1'b1;
        for (int n = 0; n < 10; n++) begin
            if (n < 3) begin
                WR_STB = 1'b1; {WR_TAG, WR_DAT} = toks[n];
                #1;
                checks++;
                if (WR_ACK !== 1'b1) begin failures++; $display("FAIL seq_wr_ack[%0d] got=%b want=1", n, WR_ACK); end
            end else begin
                WR_STB = 1'b0;
            end
            @(negedge CLK);
            stb_tr[n] = SIGN_STB | NUMBER_STB;
            both |= SIGN_STB & NUMBER_STB;
        end
        WR_STB = 1'b0;
        for (int i = 0; i < 3; i++) note_sent(toks[i]);
        checks++;
        if (stb_tr !== 10'b0000101010) begin failures++; $display("FAIL seq_stb_trace got=%b want=0000101010", stb_tr); end
        checks++;
        if (both !== 1'b0) begin failures++; $display("FAIL seq_both_stb got=1 want=0"); end
        checks++;
        if (obs.size() != 3) begin
            failures++; $display("FAIL seq_obs_count got=%0d want=3", obs.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (obs[i] !== toks[i]) begin failures++; $display("FAIL seq_obs[%0d] got=%h want=%h", i, obs[i], toks[i]); end
            end
        end
        obs.delete();
    endtask

    task automatic test_full;
        logic [8:0] toks[$];
        logic [DEPTH+1:0] acks;
        logic [8:0] t;
        int budget;
        SIGN_ACK = 1'b0; NUMBER_ACK = 1'b0;
        acks = '0;
        for (int i = 0; i < DEPTH + 2; i++) begin
            t = {1'($urandom_range(0, 1)), 8'($urandom)};
            toks.push_back(t);
            WR_STB = 1'b1; {WR_TAG, WR_DAT} = t;
            #1;
            acks[i] = WR_ACK;
            @(negedge CLK);
        end
        WR_STB = 1'b0;
        checks++;
        if (acks !== {1'b0, {(DEPTH+1){1'b1}}}) begin
            failures++; $display("FAIL full_acks got=%b want=0%b", acks, {(DEPTH+1){1'b1}});
        end
        checks++;
        if (FULL !== 1'b1) begin failures++; $display("FAIL full_flag got=%b want=1", FULL); end
        checks++;
        if (COUNT !== CW'(DEPTH)) begin failures++; $display("FAIL full_count got=%0d want=%0d", COUNT, DEPTH); end
        checks++;
        if ((SIGN_STB ^ NUMBER_STB) !== 1'b1 || BUSY !== 1'b1) begin
            failures++; $display("FAIL full_in_flight got=%b%b busy=%b want one stb busy=1", SIGN_STB, NUMBER_STB, BUSY);
        end
        SIGN_ACK = 1'b1; NUMBER_ACK = 1'b1;
        @(negedge CLK);
        WR_STB = 1'b1; WR_TAG = 1'b0; WR_DAT = 8'hEE;
        #1;
        checks++;
        if (WR_ACK !== 1'b0) begin failures++; $display("FAIL full_refuse_with_pop got=%b want=0", WR_ACK); end
        @(negedge CLK);
        WR_STB = 1'b0;
        checks++;
        if (COUNT !== CW'(DEPTH - 1)) begin failures++; $display("FAIL full_after_pop got=%0d want=%0d", COUNT, DEPTH - 1); end
        budget = 0;
        while ((BUSY || obs.size() < DEPTH + 1) && budget < 200) begin
            @(negedge CLK);
            budget++;
        end
        checks++;
        if (obs.size() != DEPTH + 1) begin
            failures++; $display("FAIL full_drain_count got=%0d want=%0d", obs.size(), DEPTH + 1);
        end else begin
            for (int i = 0; i < DEPTH + 1; i++) begin
                checks++;
                if (obs[i] !== toks[i]) begin failures++; $display("FAIL full_drain[%0d] got=%h want=%h", i, obs[i], toks[i]); end
                note_sent(toks[i]);
            end
        end
        obs.delete();
    endtask

    task automatic test_ack_ignore;
        SIGN_ACK = 1'b0; NUMBER_ACK = 1'b0;
        WR_STB = 1'b1; WR_TAG = 1'b1; WR_DAT = 8'h2D;
        @(negedge CLK);
        WR_STB = 1'b0;
        @(negedge CLK);
        checks++;
        if ({SIGN_STB, SIGN_DAT} !== {1'b1, 8'h2D}) begin
            failures++; $display("FAIL ign_send got=%b,%h want=1,2d", SIGN_STB, SIGN_DAT);
        end
        NUMBER_ACK = 1'b1;
        @(negedge CLK);
        NUMBER_ACK = 1'b0;
        checks++;
        if ({SIGN_STB, SIGN_DAT, NUMBER_STB} !== {1'b1, 8'h2D, 1'b0}) begin
            failures++; $display("FAIL ign_wrong_ack got=%b,%h,%b want=1,2d,0", SIGN_STB, SIGN_DAT, NUMBER_STB);
        end
        checks++;
        if (NUMBER_DAT !== exp_num) begin failures++; $display("FAIL ign_other_dat got=%h want=%h", NUMBER_DAT, exp_num); end
        checks++;
        if (obs.size() != 0) begin failures++; $display("FAIL ign_early_complete got=%0d want=0", obs.size()); end
        SIGN_ACK = 1'b1;
        @(negedge CLK);
        SIGN_ACK = 1'b0;
        note_sent(9'h12D);
        checks++;
        if ({SIGN_STB, BUSY} !== 2'b00 || obs.size() != 1 || obs[0] !== 9'h12D) begin
            failures++; $display("FAIL ign_complete got=%b%b n=%0d want=00 n=1", SIGN_STB, BUSY, obs.size());
        end
        obs.delete();
    endtask

    task automatic test_reset_mid_send;
        logic seen;
        seen = 1'b0;
        SIGN_ACK = 1'b0; NUMBER_ACK = 1'b0;
        for (int i = 0; i < 4; i++) begin
            WR_STB = 1'b1; WR_TAG = 1'(i % 2); WR_DAT = 8'(8'h40 + i);
            @(negedge CLK);
        end
        WR_STB = 1'b0;
        checks++;
        if (COUNT !== CW'(3) || (SIGN_STB | NUMBER_STB) !== 1'b1) begin
            failures++; $display("FAIL rst_mid_setup got=%0d stb=%b want=3 stb=1", COUNT, SIGN_STB | NUMBER_STB);
        end
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        exp_num = 8'h00; exp_sign = 8'h00;
        checks++;
        if ({SIGN_STB, NUMBER_STB, BUSY} !== 3'b000 || COUNT !== '0) begin
            failures++; $display("FAIL rst_mid_clear got=%b%b%b cnt=%0d want=000 cnt=0", SIGN_STB, NUMBER_STB, BUSY, COUNT);
        end
        SIGN_ACK = 1'b1; NUMBER_ACK = 1'b1;
        repeat (10) begin
            @(negedge CLK);
            seen |= SIGN_STB | NUMBER_STB;
        end
        checks++;
        if (seen !== 1'b0 || obs.size() != 0) begin
            failures++; $display("FAIL rst_mid_discard got=%b n=%0d want=0 n=0", seen, obs.size());
        end
        obs.delete();
    endtask

    task automatic test_random;
        logic [8:0] exp_q[$];
        logic [8:0] t;
        logic prev_done;
        int budget;
        prev_done = 1'b0;
        obs.delete();
        for (int c = 0; c < 400; c++) begin
            @(negedge CLK);
            if (prev_done) begin
                checks++;
                if ((SIGN_STB | NUMBER_STB) !== 1'b0) begin failures++; $display("FAIL rand_gap cyc=%0d got=1 want=0", c); end
            end
            if (SIGN_STB & NUMBER_STB) begin
                checks++; failures++; $display("FAIL rand_onehot cyc=%0d got=11 want=one", c);
            end
            t = {1'($urandom_range(0, 1)), 8'($urandom)};
            WR_STB = ($urandom_range(0, 2) != 0);
            {WR_TAG, WR_DAT} = t;
            SIGN_ACK = ($urandom_range(0, 2) != 0);
            NUMBER_ACK = ($urandom_range(0, 2) != 0);
            #1;
            if (WR_ACK) exp_q.push_back(t);
            prev_done = (SIGN_STB & SIGN_ACK) | (NUMBER_STB & NUMBER_ACK);
        end
        @(negedge CLK);
        WR_STB = 1'b0; SIGN_ACK = 1'b1; NUMBER_ACK = 1'b1;
        budget = 0;
        while ((BUSY || obs.size() < exp_q.size()) && budget < 200) begin
            @(negedge CLK);
            budget++;
        end
        checks++;
        if (obs.size() != exp_q.size() || exp_q.size() == 0) begin
            failures++; $display("FAIL rand_count got=%0d want=%0d", obs.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                checks++;
                if (obs[i] !== exp_q[i]) begin failures++; $display("FAIL rand_tok[%0d] got=%h want=%h", i, obs[i], exp_q[i]); end
            end
        end
        obs.delete();
    endtask

`ifdef TOKEN_TX_HOLD_EN
    task automatic test_hold;
        logic seen;
        int budget;
        seen = 1'b0;
        SIGN_ACK = 1'b1; NUMBER_ACK = 1'b1;
        @(negedge CLK);
        HOLD = 1'b1;
        WR_STB = 1'b1; WR_TAG = 1'b0; WR_DAT = 8'h11;
        @(negedge CLK);
        WR_TAG = 1'b1; WR_DAT = 8'h22;
        @(negedge CLK);
        WR_STB = 1'b0;
        repeat (10) begin
            @(negedge CLK);
            seen |= SIGN_STB | NUMBER_STB;
        end
        checks++;
        if (seen !== 1'b0 || COUNT !== CW'(2)) begin
            failures++; $display("FAIL hold_block got=%b cnt=%0d want=0 cnt=2", seen, COUNT);
        end
        HOLD = 1'b0;
        budget = 0;
        while ((BUSY || obs.size() < 2) && budget < 50) begin
            @(negedge CLK);
            budget++;
        end
        checks++;
        if (obs.size() != 2 || obs[0] !== 9'h011 || obs[1] !== 9'h122) begin
            failures++; $display("FAIL hold_release got_n=%0d want=011,122", obs.size());
        end
        obs.delete();
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_sequence();
        test_full();
        test_ack_ignore();
        test_reset_mid_send();
        test_random();
`ifdef TOKEN_TX_HOLD_EN
        test_hold();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end
endmodule
